fft_bin_serializer: RTL and testbench
=====================================

Name: fft_bin_serializer

Overview:
- Receiving end of the FFT block's parallel frame interface (fft_valid plus fft_d0..fft_d15).
- Captures each 16-bin frame into a two-slot ping-pong buffer.
- Replays the bins one per handshake on a valid/ready stream, bin 0 first, with an index tag and a last marker.
- Feeds downstream analysis and the host readout path; counts and flags frames dropped under backpressure.

Parameters:
NBINS, 16, bins per frame; index width is log2(NBINS).
DW, 32, bin word width: [31:16] real, [15:0] imag, 8.8 signed each.
SLOTS, 2, frame buffer depth; fixed at 2.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-low reset; rst=0 at a rising edge resets the block.
fft_valid  input  1  one complete frame is present on fft_d0..fft_d15 this cycle.
fft_d0..fft_d15  input  32 each  bin words; fft_dK is bin K.
ovf_clr  input  1  clears the sticky ovf flag.
out_ready  input  1  downstream accepts out_data this cycle.
out_valid  output  1  out_data, out_idx and out_last are valid.
out_data  output  32  current bin word; forced to 0 when out_valid=0.
out_idx  output  4  bin number of out_data, 0..15.
out_last  output  1  high with bin 15 of a frame.
ovf  output  1  sticky; set when a frame is dropped.
drop_cnt  output  8  dropped-frame count; saturates at 255.
busy  output  1  high when at least one frame is buffered.

Behaviour:
- Reset (rst=0 at an edge): count=0, wp=0, rp=0, idx=0, out_valid=0, out_data=0, out_idx=0, out_last=0, ovf=0, drop_cnt=0, busy=0. Slot contents are don't-care. A reset mid-frame discards all buffered frames with no partial output afterwards.
- State: slot[0..1] of NBINS x DW; write pointer wp, read pointer rp, occupancy count (0..2), read index idx.
- Handshake: "xfer" = out_valid && out_ready.
- Release: "release" = xfer && idx==NBINS-1.
- Capture rule at an edge with fft_valid=1:
  - Accept if count<2, or count==2 && release in the same cycle.
  - Accept action: all 16 words go to slot[wp], and wp toggles.
- Drop rule: fft_valid=1 with count==2 and no release drops the frame.
  - ovf is set; drop_cnt increments, saturating at 255.
  - Slot contents and pointers are unchanged.
- Back-to-back frames: fft_valid high on consecutive cycles means one new frame per cycle; each is judged independently.
- Occupancy update: count_next = count + accept - release.
- Output mapping:
  - out_valid = (count>0).
  - out_data = slot[rp][idx], out_idx = idx, out_last = (idx==NBINS-1) && out_valid.
  - All are driven from registers through the read mux; there is no combinational path from fft_valid or fft_d* to the outputs.
- Latency: a frame accepted at edge N with the buffer empty gives out_valid=1, idx=0 after edge N, so it is visible in cycle N+1. Minimum 16 cycles per frame drain with out_ready held high.
- Stalls: while out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable.
- Index advance: xfer advances idx. On release, idx returns to 0 and rp toggles; the next frame's bin 0 is presented the following cycle with no bubble.
- State machine:
  - EMPTY (count=0) -> LOADED on accept.
  - LOADED (count=1) -> FULL on accept without release; -> EMPTY on release without accept; stays LOADED on accept+release.
  - FULL (count=2) -> LOADED on release without accept; stays FULL on release+accept.
- ovf flag: ovf_clr=1 clears ovf. If ovf_clr and a drop coincide, set wins. drop_cnt is cleared only by reset.
- busy = (count>0); it equals out_valid.
- Arithmetic: pure storage; no rounding and no sign handling on bin words.

Decomposition:
- Package fas_pkg holds:
  - NBINS=16, DW=32, IDXW=4.
  - Typedef bin_word_t (DW bits), with real/imag field constants RE_MSB=31, RE_LSB=16, IM_MSB=15, IM_LSB=0.
  - Typedef frame_t (array of NBINS bin_word_t).
- One natural sub-module: fas_frame_slot, one 16x32 register bank with write-enable and an indexed read port, instantiated twice.
- Pointer, occupancy and handshake logic stay in the top.

Test Plan:
- Single frame, fft_dK=32'h0001_0000*K+K, out_ready=1 -> 16 beats in cycles N+1..N+16, out_idx 0..15, out_data matches per bin, out_last only on beat 16, then out_valid=0.
- Backpressure: same frame, out_ready toggling 1,0,0,1,... -> every beat delivered exactly once in order, out_data stable during each stall, no loss.
- Three frames A,B,C on consecutive cycles, out_ready=0 -> A,B stored; C dropped; ovf=1, drop_cnt=1. Then out_ready=1 -> A then B, 32 beats with no gap.
- Full buffer, frame D arrives in the same cycle as A's bin-15 handshake -> D accepted, ovf unchanged, output order B then D.
- Drop and ovf_clr in the same cycle -> ovf stays 1. 300 forced drops -> drop_cnt=255 and holds.
- rst=0 for one edge while mid-way through a frame (idx=7) -> next cycle out_valid=0, out_data=0, ovf=0, drop_cnt=0. A new frame afterwards starts at idx 0.

Source files
------------

// File: rtl/fas_pkg.sv
// Shared types and constants for the FFT bin serializer: bin word layout,
// frame container and buffer occupancy states.
package fas_pkg;
  localparam int NBINS  = 16;
  localparam int DW     = 32;
  localparam int IDXW   = 4;
  localparam int RE_MSB = 31;
  localparam int RE_LSB = 16;
  localparam int IM_MSB = 15;
  localparam int IM_LSB = 0;

  typedef logic [DW-1:0] bin_word_t;
  typedef bin_word_t [NBINS-1:0] frame_t;

  // Occupancy of the two-slot ping-pong buffer; encoding equals frame count.
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_LOADED = 2'd1,
    ST_FULL   = 2'd2
  } occ_state_t;
endpackage

// File: rtl/fft_bin_serializer_if.sv
// Bin output stream: one bin word per valid/ready handshake, tagged with its
// bin index and a last marker on bin NBINS-1.
interface fft_bin_serializer_if;
  import fas_pkg::*;

  logic                out_valid;
  logic                out_ready;
  bin_word_t           out_data;
  logic [IDXW-1:0]     out_idx;
  logic                out_last;

  modport master (output out_valid, output out_data, output out_idx, output out_last,
                  input  out_ready);
  modport slave  (input  out_valid, input  out_data, input  out_idx, input  out_last,
                  output out_ready);
endinterface

// File: rtl/fas_frame_slot.sv
// One frame slot: NBINS x DW register bank written as a whole frame and read
// one bin at a time.
module fas_frame_slot
  import fas_pkg::*;
(
  input  logic            clk,
  input  logic            we,
  input  frame_t          wdata,
  input  logic [IDXW-1:0] rd_idx,
  output bin_word_t       rdata
);
  frame_t bank_r;

  // Whole-frame capture; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (we) begin
      bank_r <= wdata;
    end
  end

  assign rdata = bank_r[rd_idx];
endmodule

// File: rtl/fft_bin_serializer.sv
// Captures parallel FFT frames into a two-slot ping-pong buffer and replays
// them bin by bin on a valid/ready stream; counts frames dropped when full.
module fft_bin_serializer
  import fas_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fft_valid,
  input  bin_word_t                   fft_d0,
  input  bin_word_t                   fft_d1,
  input  bin_word_t                   fft_d2,
  input  bin_word_t                   fft_d3,
  input  bin_word_t                   fft_d4,
  input  bin_word_t                   fft_d5,
  input  bin_word_t                   fft_d6,
  input  bin_word_t                   fft_d7,
  input  bin_word_t                   fft_d8,
  input  bin_word_t                   fft_d9,
  input  bin_word_t                   fft_d10,
  input  bin_word_t                   fft_d11,
  input  bin_word_t                   fft_d12,
  input  bin_word_t                   fft_d13,
  input  bin_word_t                   fft_d14,
  input  bin_word_t                   fft_d15,
  input  logic                        ovf_clr,
  fft_bin_serializer_if.master        strm,
  output logic                        ovf,
  output logic [7:0]                  drop_cnt,
  output logic                        busy
);
  occ_state_t      state_r, state_s;
  logic            wp_r, rp_r;
  logic [IDXW-1:0] idx_r;
  logic            ovf_r;
  logic [7:0]      drop_cnt_r;

  frame_t          fft_frame_s;
  bin_word_t       rd0_s, rd1_s;
  logic            valid_s, xfer_s, rel_s, acc_s, drop_s;

  assign fft_frame_s = {fft_d15, fft_d14, fft_d13, fft_d12, fft_d11, fft_d10, fft_d9, fft_d8,
                        fft_d7,  fft_d6,  fft_d5,  fft_d4,  fft_d3,  fft_d2,  fft_d1, fft_d0};

  assign valid_s = (state_r != ST_EMPTY);
  assign xfer_s  = valid_s && strm.out_ready;
  assign rel_s   = xfer_s && (idx_r == IDXW'(NBINS-1));
  // A full buffer still accepts when the oldest frame retires on this same edge.
  assign acc_s   = fft_valid && ((state_r != ST_FULL) || rel_s);
  assign drop_s  = fft_valid && (state_r == ST_FULL) && !rel_s;

  fas_frame_slot u_slot0 (
    .clk    (clk),
    .we     (acc_s && !wp_r && rst),
    .wdata  (fft_frame_s),
    .rd_idx (idx_r),
    .rdata  (rd0_s)
  );

  fas_frame_slot u_slot1 (
    .clk    (clk),
    .we     (acc_s && wp_r && rst),
    .wdata  (fft_frame_s),
    .rd_idx (idx_r),
    .rdata  (rd1_s)
  );

  // Occupancy next-state from accept/release.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (acc_s) state_s = ST_LOADED;
        else       state_s = ST_EMPTY;
      end
      ST_LOADED: begin
        if (acc_s && !rel_s)      state_s = ST_FULL;
        else if (!acc_s && rel_s) state_s = ST_EMPTY;
        else                      state_s = ST_LOADED;
      end
      ST_FULL: begin
        if (rel_s && !acc_s) state_s = ST_LOADED;
        else                 state_s = ST_FULL;
      end
      default: state_s = ST_EMPTY;
    endcase
  end

  // Pointers, read index, overflow flag and drop counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_EMPTY;
      wp_r       <= 1'b0;
      rp_r       <= 1'b0;
      idx_r      <= '0;
      ovf_r      <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else begin
      state_r <= state_s;
      if (acc_s) wp_r <= ~wp_r;
      if (rel_s) begin
        rp_r  <= ~rp_r;
        idx_r <= '0;
      end else if (xfer_s) begin
        idx_r <= idx_r + IDXW'(1);
      end
      if (drop_s)       ovf_r <= 1'b1;
      else if (ovf_clr) ovf_r <= 1'b0;
      if (drop_s && (drop_cnt_r != 8'd255)) drop_cnt_r <= drop_cnt_r + 8'd1;
    end
  end

  // Read mux from registered state; data is zeroed while nothing is buffered.
  always_comb begin
    if (valid_s) begin
      strm.out_data = rp_r ? rd1_s : rd0_s;
    end else begin
      strm.out_data = '0;
    end
  end

  assign strm.out_valid = valid_s;
  assign strm.out_idx   = idx_r;
  assign strm.out_last  = valid_s && (idx_r == IDXW'(NBINS-1));
  assign ovf            = ovf_r;
  assign drop_cnt       = drop_cnt_r;
  assign busy           = valid_s;
endmodule

// File: tb/tb_fft_bin_serializer.sv
// Directed bench for fft_bin_serializer: a vector table for a plain frame
// drain plus hand-written sequences for backpressure, drops and reset.
module tb_fft_bin_serializer;
  logic        clk = 1'b0;
  logic        rst;
  logic        fft_valid;
  logic [31:0] fft_d [16];
  logic        ovf_clr;
  logic        ovf;
  logic [7:0]  drop_cnt;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;

  fft_bin_serializer_if sif ();

  fft_bin_serializer dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(fft_d[0]),   .fft_d1(fft_d[1]),   .fft_d2(fft_d[2]),   .fft_d3(fft_d[3]),
    .fft_d4(fft_d[4]),   .fft_d5(fft_d[5]),   .fft_d6(fft_d[6]),   .fft_d7(fft_d[7]),
    .fft_d8(fft_d[8]),   .fft_d9(fft_d[9]),   .fft_d10(fft_d[10]), .fft_d11(fft_d[11]),
    .fft_d12(fft_d[12]), .fft_d13(fft_d[13]), .fft_d14(fft_d[14]), .fft_d15(fft_d[15]),
    .ovf_clr(ovf_clr), .strm(sif), .ovf(ovf), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    int          frm;
    logic        rdy;
    logic        exp_valid;
    logic [3:0]  exp_idx;
    logic [31:0] exp_data;
    logic        exp_last;
  } vec_t;

  vec_t tbl [17];

  // Frame f, bin k; frame 0 is 32'h0001_0000*k + k.
  function automatic logic [31:0] w(input int f, input int k);
    return 32'(32'h0001_0000 * k + k + f * 32'h1000_1000);
  endfunction

  function automatic logic [63:0] beat(input int f, input int k);
    logic [3:0] k4;
    k4 = k[3:0];
    return {26'd0, 1'b1, k4, (k == 15), w(f, k)};
  endfunction

  function automatic logic [63:0] obs();
    return {26'd0, sif.out_valid, sif.out_idx, sif.out_last, sif.out_data};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int f);
    for (int k = 0; k < 16; k++) fft_d[k] = w(f, k);
    fft_valid = 1'b1;
  endtask

  task automatic drain(input string nm, input int f0, input int f1, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      chk($sformatf("%s_beat%0d", nm, b), obs(), beat((b < 16) ? f0 : f1, b % 16));
      tick();
    end
    chk($sformatf("%s_idle", nm), 64'(sif.out_valid), 64'd0);
  endtask

  initial begin
    int got;
    int cyc;
    logic [63:0] held;

    rst = 1'b0; fft_valid = 1'b0; ovf_clr = 1'b0; sif.out_ready = 1'b0;
    for (int k = 0; k < 16; k++) fft_d[k] = 32'd0;
    tick();
    chk("reset_state", {obs(), ovf, drop_cnt, busy}, 64'd0);
    rst = 1'b1;

    // Single frame drain with out_ready held high.
    tbl[0] = '{1'b1, 0, 1'b1, 1'b1, 4'd0, w(0, 0), 1'b0};
    for (int k = 1; k < 16; k++)
      tbl[k] = '{1'b0, 0, 1'b1, 1'b1, 4'(k), w(0, k), (k == 15)};
    tbl[16] = '{1'b0, 0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0};
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].fv) load(tbl[i].frm);
      else fft_valid = 1'b0;
      sif.out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d", i), obs(),
          {26'd0, tbl[i].exp_valid, tbl[i].exp_idx, tbl[i].exp_last, tbl[i].exp_data});
    end
    fft_valid = 1'b0;

    // Backpressure with out_ready = 1,0,0,1,0,0,...
    sif.out_ready = 1'b0;
    load(1); tick(); fft_valid = 1'b0;
    got = 0; cyc = 0;
    while (got < 16 && cyc < 100) begin
      sif.out_ready = (cyc % 3 == 0);
      if (sif.out_ready) begin
        chk($sformatf("bp_beat%0d", got), obs(), beat(1, got));
        got++;
        tick();
      end else begin
        held = obs();
        tick();
        chk($sformatf("bp_stall%0d", cyc), obs(), held);
      end
      cyc++;
    end
    chk("bp_all_beats", 64'(got), 64'd16);
    chk("bp_idle", 64'(sif.out_valid), 64'd0);

    // Three back-to-back frames into a stalled buffer: third is dropped.
    sif.out_ready = 1'b0;
    load(2); tick(); load(3); tick(); load(4); tick(); fft_valid = 1'b0;
    chk("abc_flags", {ovf, drop_cnt, busy}, {1'b1, 8'd1, 1'b1});
    sif.out_ready = 1'b1;
    drain("abc", 2, 3, 32);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_cleared", 64'(ovf), 64'd0);

    // Accept into a full buffer on the same edge as the bin-15 release.
    sif.out_ready = 1'b0;
    load(5); tick(); load(6); tick(); fft_valid = 1'b0;
    sif.out_ready = 1'b1;
    for (int b = 0; b < 15; b++) tick();
    chk("rel_at_15", obs(), beat(5, 15));
    load(7); tick(); fft_valid = 1'b0;
    chk("rel_acc_flags", {ovf, drop_cnt, busy}, {1'b0, 8'd1, 1'b1});
    drain("bd", 6, 7, 32);

    // Drop coinciding with ovf_clr, then counter saturation.
    sif.out_ready = 1'b0;
    load(8); tick(); load(9); tick();
    load(10); ovf_clr = 1'b1; tick(); ovf_clr = 1'b0; fft_valid = 1'b0;
    chk("drop_vs_clr", {ovf, drop_cnt}, {1'b1, 8'd2});
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("clr_alone", 64'(ovf), 64'd0);
    load(11);
    repeat (300) tick();
    chk("drop_sat", {ovf, drop_cnt}, {1'b1, 8'd255});
    tick(); fft_valid = 1'b0;
    chk("drop_sat_hold", 64'(drop_cnt), 64'd255);

    // Buffered frame 8 is intact; reset when idx reaches 7.
    sif.out_ready = 1'b1;
    for (int b = 0; b < 7; b++) begin
      chk($sformatf("pre_rst_beat%0d", b), obs(), beat(8, b));
      tick();
    end
    chk("pre_rst_idx7", obs(), beat(8, 7));
    rst = 1'b0; tick(); rst = 1'b1;
    chk("mid_reset", {obs(), ovf, drop_cnt, busy}, 64'd0);
    tick();
    chk("post_rst_idle", 64'(sif.out_valid), 64'd0);
    load(12); tick(); fft_valid = 1'b0;
    drain("post_rst", 12, 12, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
